// File: rtl/rs_hs_pipeline_tail_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rs_hs_pipeline_tail_fifo
//  Description : Tail FIFO of a registered-ready handshake pipeline. It always
//                accepts in-flight words (up to physical capacity) and returns
//                a registered credit signal that deasserts early enough to
//                absorb GRACE_PERIOD in-flight words. First-word-fall-through
//                output with one-cycle write-to-read latency.
//  Options     : RS_HS_TAIL_OVERFLOW_CHECK_EN - enables sticky overflow_err
//                set on any discarded push.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_hs_pipeline_tail_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 24,
    parameter int GRACE_PERIOD    = 9,
    parameter int REAL_DEPTH      = GRACE_PERIOD + DEPTH + 4,
    parameter int REAL_ADDR_WIDTH = $clog2(REAL_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       if_din_valid,
    input  logic [DATA_WIDTH-1:0]      if_din_data,
    output logic                       if_din_ready,
    output logic                       if_dout_valid,
    output logic [DATA_WIDTH-1:0]      if_dout_data,
    input  logic                       if_dout_ready,
    output logic [REAL_ADDR_WIDTH-1:0] occupancy,
    output logic                       overflow_err
);

    localparam logic [REAL_ADDR_WIDTH-1:0] c_real_depth = REAL_ADDR_WIDTH'(REAL_DEPTH);
    localparam logic [REAL_ADDR_WIDTH-1:0] c_last_ptr   = REAL_ADDR_WIDTH'(REAL_DEPTH - 1);
    localparam logic [REAL_ADDR_WIDTH-1:0] c_grace      = REAL_ADDR_WIDTH'(GRACE_PERIOD);
    localparam logic [REAL_ADDR_WIDTH-1:0] c_one        = REAL_ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0]      r_mem [REAL_DEPTH];
    logic [REAL_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [REAL_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [REAL_ADDR_WIDTH-1:0] r_occupancy;
    logic                       r_din_ready;

    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic [REAL_ADDR_WIDTH-1:0] w_occ_next;
    logic                       w_ready_next;
    logic [REAL_ADDR_WIDTH-1:0] w_wr_ptr_inc;
    logic [REAL_ADDR_WIDTH-1:0] w_rd_ptr_inc;

    // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
    // can still take a push when the consumer is draining.
    always_comb begin
        w_full       = (r_occupancy == c_real_depth);
        w_pop        = (r_occupancy != '0) && if_dout_ready;
        w_push       = if_din_valid && (!w_full || w_pop);
        w_occ_next   = r_occupancy + REAL_ADDR_WIDTH'(w_push) - REAL_ADDR_WIDTH'(w_pop);
        w_ready_next = ((c_real_depth - w_occ_next) > c_grace);
        w_wr_ptr_inc = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_one;
        w_rd_ptr_inc = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_one;
    end

    // Pointer, occupancy and credit registers; credit looks at next occupancy
    // so the head sees the deassertion as early as possible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
            r_din_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_occupancy <= w_occ_next;
            r_din_ready <= w_ready_next;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= if_din_data;
    end

    assign if_din_ready  = r_din_ready;
    assign if_dout_valid = (r_occupancy != '0);
    assign if_dout_data  = r_mem[r_rd_ptr];
    assign occupancy     = r_occupancy;

`ifdef RS_HS_TAIL_OVERFLOW_CHECK_EN
    logic r_overflow_err;

    // Sticky flag raised when an arriving word is discarded for lack of space.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow_err <= 1'b0;
        end else if (if_din_valid && w_full && !w_pop) begin
            r_overflow_err <= 1'b1;
        end
    end

    assign overflow_err = r_overflow_err;
`else
    assign overflow_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_hs_pipeline_tail_fifo
//  Description : Self-checking bench for rs_hs_pipeline_tail_fifo using a
//                queue-based reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_hs_pipeline_tail_fifo;

    localparam int c_dw  = 32;
    localparam int c_rd  = 37;
    localparam int c_gr  = 9;
    localparam int c_aw  = 6;

    logic              clk;
    logic              reset;
    logic              if_din_valid;
    logic [c_dw-1:0]   if_din_data;
    logic              if_din_ready;
    logic              if_dout_valid;
    logic [c_dw-1:0]   if_dout_data;
    logic              if_dout_ready;
    logic [c_aw-1:0]   occupancy;
    logic              overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [c_dw-1:0] model_q [$];
    logic            model_dropped;

    rs_hs_pipeline_tail_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .if_din_valid  (if_din_valid),
        .if_din_data   (if_din_data),
        .if_din_ready  (if_din_ready),
        .if_dout_valid (if_dout_valid),
        .if_dout_data  (if_dout_data),
        .if_dout_ready (if_dout_ready),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return ((c_rd - model_q.size()) > c_gr);
    endfunction

    function automatic logic exp_ovf();
`ifdef RS_HS_TAIL_OVERFLOW_CHECK_EN
        return model_dropped;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: apply inputs, advance the model by the FIFO rules, settle.
    task automatic cycle(input logic v, input logic [c_dw-1:0] d, input logic r);
        logic pop;
        logic push;
        if_din_valid  = v;
        if_din_data   = d;
        if_dout_ready = r;
        pop  = (model_q.size() != 0) && r;
        push = v && ((model_q.size() < c_rd) || pop);
        @(posedge clk);
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(d);
        if (v && !push) model_dropped = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_din_valid = 1'b0; if_din_data = '0; if_dout_ready = 1'b0;
        model_q.delete(); model_dropped = 1'b0;
        #12;
        n_checks++; if (occupancy !== 6'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (if_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_dout_valid); end
        n_checks++; if (if_din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", if_din_ready); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_latency();
        n_checks++; if (if_dout_valid !== 1'b0) begin n_fail++; $display("FAIL lat_before got=%b exp=0", if_dout_valid); end
        cycle(1'b1, 32'hA5A5A5A5, 1'b0);
        n_checks++; if (if_dout_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got=%b exp=1", if_dout_valid); end
        n_checks++; if (if_dout_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL lat_data got=%h exp=a5a5a5a5", if_dout_data); end
        n_checks++; if (occupancy !== 6'd1) begin n_fail++; $display("FAIL lat_occ got=%0d exp=1", occupancy); end
        cycle(1'b0, '0, 1'b1);
        n_checks++; if (if_dout_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pop_valid got=%b exp=0", if_dout_valid); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < c_rd; k++) begin
            cycle(1'b1, $urandom, 1'b0);
            n_checks++;
            if (occupancy !== c_aw'(model_q.size())) begin
                n_fail++; $display("FAIL fill_occ step=%0d got=%0d exp=%0d", k, occupancy, model_q.size());
            end
            n_checks++;
            if (if_din_ready !== exp_ready()) begin
                n_fail++; $display("FAIL fill_ready step=%0d got=%b exp=%b", k, if_din_ready, exp_ready());
            end
        end
        n_checks++; if (occupancy !== 6'd37) begin n_fail++; $display("FAIL fill_full got=%0d exp=37", occupancy); end
    endtask

    task automatic test_full_push_pop();
        n_checks++; if (if_dout_data !== model_q[0]) begin n_fail++; $display("FAIL fpp_head got=%h exp=%h", if_dout_data, model_q[0]); end
        cycle(1'b1, 32'h0000BEEF, 1'b1);
        n_checks++; if (occupancy !== 6'd37) begin n_fail++; $display("FAIL fpp_occ got=%0d exp=37", occupancy); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got=%b exp=0", overflow_err); end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 32'hDEADDEAD, 1'b0);
        n_checks++; if (occupancy !== 6'd37) begin n_fail++; $display("FAIL ovf_occ got=%0d exp=37", occupancy); end
        n_checks++; if (overflow_err !== exp_ovf()) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", overflow_err, exp_ovf()); end
    endtask

    task automatic test_drain();
        for (int k = 0; k < c_rd; k++) begin
            n_checks++;
            if (if_dout_data !== model_q[0]) begin
                n_fail++; $display("FAIL drain_data idx=%0d got=%h exp=%h", k, if_dout_data, model_q[0]);
            end
            cycle(1'b0, '0, 1'b1);
        end
        n_checks++; if (if_dout_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", if_dout_valid); end
        n_checks++; if (if_din_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got=%b exp=1", if_din_ready); end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 10; k++) cycle(1'b1, k, 1'b0);
        n_checks++; if (occupancy !== 6'd10) begin n_fail++; $display("FAIL mid_pre_occ got=%0d exp=10", occupancy); end
        if_din_valid = 1'b1; if_din_data = 32'h12345678;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (occupancy !== 6'd0) begin n_fail++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
        n_checks++; if (if_dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", if_dout_valid); end
        n_checks++; if (if_din_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", if_din_ready); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got=%b exp=0", overflow_err); end
        @(posedge clk); #1;
        n_checks++; if (if_dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_inflight got=%b exp=0", if_dout_valid); end
        @(negedge clk);
        if_din_valid = 1'b0;
        reset = 1'b1;
        model_q.delete(); model_dropped = 1'b0;
    endtask

    task automatic test_wrap_random();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic v;
        logic r;
        while ((recv < 100) && (cyc < 3000)) begin
            v = (sent < 100) && if_din_ready && (($urandom % 4) != 0);
            r = (($urandom % 3) != 0);
            if (if_dout_valid && r) begin
                n_checks++;
                if (if_dout_data !== c_dw'(recv)) begin
                    n_fail++; $display("FAIL wrap_data idx=%0d got=%0d exp=%0d", recv, if_dout_data, recv);
                end
                recv++;
            end
            cycle(v, c_dw'(sent), r);
            if (v) sent++;
            cyc++;
            n_checks++;
            if (occupancy !== c_aw'(model_q.size())) begin
                n_fail++; $display("FAIL wrap_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, model_q.size());
            end
        end
        n_checks++;
        if (recv != 100) begin n_fail++; $display("FAIL wrap_timeout got=%0d exp=100", recv); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%b exp=0", overflow_err); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_full_push_pop();
        test_overflow();
        test_drain();
        test_reset_midstream();
        test_wrap_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
